// File: rtl/shift_deserializer_pkg.sv
// Shared definitions for the shift register family: FSM state encoding and
// serial bit-order constants used by the serializer and the deserializer.
package shift_defs;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic DIR_LSB = 1'b0;
  localparam logic DIR_MSB = 1'b1;

endpackage

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: gathers WIDTH strobed bits (LSB- or MSB-first)
// into a word and offers it on a single-entry valid/ready output buffer.
module shift_deserializer
  import shift_defs::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_din,
  input  logic             s_valid,
  input  logic             msb_first,
  input  logic             clear,
  output logic [WIDTH-1:0] p_dout,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [WIDTH-1:0] sh, sh_nxt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] p_dout_nxt;
  logic             dir, dir_nxt;
  logic             bit_dir;
  logic             p_valid_nxt;
  logic             overrun_nxt;
  logic             consume;

  // Bit order is taken live from msb_first on the first bit, then from the latched dir.
  always_comb begin
    bit_dir = (state == ST_IDLE) ? msb_first : dir;
    if (bit_dir == DIR_MSB) begin
      shifted = {sh[WIDTH-2:0], s_din};
    end else begin
      shifted = {s_din, sh[WIDTH-1:1]};
    end
  end

  assign consume = p_valid && p_ready;

  // Next-state, assembly and output-buffer decisions; clear overrides everything.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    sh_nxt      = sh;
    dir_nxt     = dir;
    p_dout_nxt  = p_dout;
    p_valid_nxt = p_valid;
    overrun_nxt = overrun;
    if (clear) begin
      state_nxt   = ST_IDLE;
      count_nxt   = '0;
      sh_nxt      = '0;
      dir_nxt     = DIR_LSB;
      p_valid_nxt = 1'b0;
      overrun_nxt = 1'b0;
    end else begin
      if (consume) begin
        p_valid_nxt = 1'b0;
      end
      if (s_valid) begin
        sh_nxt = shifted;
        if (state == ST_IDLE) begin
          dir_nxt = msb_first;
        end
        if (count == LAST) begin
          state_nxt = ST_IDLE;
          count_nxt = '0;
          if (!p_valid || p_ready) begin
            p_dout_nxt  = shifted;
            p_valid_nxt = 1'b1;
          end else begin
            overrun_nxt = 1'b1;
          end
        end else begin
          state_nxt = ST_SHIFT;
          count_nxt = count + CW'(1);
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and output buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      sh      <= '0;
      dir     <= DIR_LSB;
      p_dout  <= '0;
      p_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      count   <= count_nxt;
      sh      <= sh_nxt;
      dir     <= dir_nxt;
      p_dout  <= p_dout_nxt;
      p_valid <= p_valid_nxt;
      overrun <= overrun_nxt;
    end
  end

  assign busy = (state == ST_SHIFT);

  // The counter never reaches WIDTH; it returns to zero on the completing bit.
  a_count_range : assert property (@(posedge clk) disable iff (!rst_n) count <= LAST);

  // IDLE and a zero bit count always go together.
  a_state_count : assert property (@(posedge clk) disable iff (!rst_n)
    (state == ST_IDLE) == (count == '0));

  // A word waiting for the consumer is never overwritten.
  a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (p_valid && !p_ready && !clear) |=> ($stable(p_dout) && p_valid));

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer: table-driven words plus
// hand-written multi-cycle sequences, with a scoreboard of expected words.
module tb_shift_deserializer;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_din;
  logic             s_valid;
  logic             msb_first;
  logic             clear;
  logic [WIDTH-1:0] p_dout;
  logic             p_valid;
  logic             p_ready;
  logic             busy;
  logic             overrun;

  shift_deserializer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_din    (s_din),
    .s_valid  (s_valid),
    .msb_first(msb_first),
    .clear    (clear),
    .p_dout   (p_dout),
    .p_valid  (p_valid),
    .p_ready  (p_ready),
    .busy     (busy),
    .overrun  (overrun)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] seq;
    logic             msb;
    int               gap;
    logic [WIDTH-1:0] expw;
  } vec_t;

  vec_t             vecs[8];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_word;
  int               checks = 0;
  int               errors = 0;

  logic             m_valid;
  logic             m_overrun;
  int               m_count;
  logic             prev_m_valid;
  logic             ready_at_edge;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance the behavioural model with the inputs being driven, clock once, then compare.
  task automatic stepCycle();
    logic old_valid;
    logic new_word;
    logic [WIDTH-1:0] got;
    old_valid     = m_valid;
    ready_at_edge = p_ready;
    if (clear) begin
      m_count   = 0;
      m_valid   = 1'b0;
      m_overrun = 1'b0;
    end else begin
      if (old_valid && p_ready) m_valid = 1'b0;
      if (s_valid) begin
        if (m_count == WIDTH - 1) begin
          m_count = 0;
          if (!old_valid || p_ready) begin
            m_valid = 1'b1;
            exp_q.push_back(exp_word);
          end else begin
            m_overrun = 1'b1;
          end
        end else begin
          m_count++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("p_valid", {31'd0, p_valid}, {31'd0, m_valid});
    checkOutput("busy", {31'd0, busy}, {31'd0, (m_count != 0)});
    checkOutput("overrun", {31'd0, overrun}, {31'd0, m_overrun});
    new_word = m_valid && (!prev_m_valid || ready_at_edge);
    if (new_word) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard: word %0h appeared with nothing expected", p_dout);
      end else begin
        got = p_dout;
        checkOutput("p_dout", {28'd0, got}, {28'd0, exp_q.pop_front()});
      end
    end
    prev_m_valid = m_valid;
  endtask

  task automatic applyStimulus(input logic valid, input logic din, input logic ready,
                               input logic msb, input logic clr);
    s_valid   = valid;
    s_din     = din;
    p_ready   = ready;
    msb_first = msb;
    clear     = clr;
    stepCycle();
  endtask

  // Send one word; seq[0] is the first bit on the wire.
  task automatic sendWord(input logic [WIDTH-1:0] seq, input logic msb, input int gap,
                          input logic ready, input logic [WIDTH-1:0] expw);
    exp_word = expw;
    for (int i = 0; i < WIDTH; i++) begin
      applyStimulus(1'b1, seq[i], ready, msb, 1'b0);
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, ready, msb, 1'b0);
    end
  endtask

  task automatic modelReset();
    m_count      = 0;
    m_valid      = 1'b0;
    m_overrun    = 1'b0;
    prev_m_valid = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{seq: 4'b1101, msb: 1'b0, gap: 0, expw: 4'b1101};
    vecs[1] = '{seq: 4'b0110, msb: 1'b0, gap: 0, expw: 4'b0110};
    vecs[2] = '{seq: 4'b1011, msb: 1'b1, gap: 0, expw: 4'b1101};
    vecs[3] = '{seq: 4'b0001, msb: 1'b1, gap: 1, expw: 4'b1000};
    vecs[4] = '{seq: 4'b0001, msb: 1'b0, gap: 3, expw: 4'b0001};
    vecs[5] = '{seq: 4'b1100, msb: 1'b1, gap: 0, expw: 4'b0011};
    vecs[6] = '{seq: 4'b1111, msb: 1'b0, gap: 0, expw: 4'b1111};
    vecs[7] = '{seq: 4'b0010, msb: 1'b1, gap: 2, expw: 4'b0100};

    rst_n     = 1'b0;
    s_din     = 1'b0;
    s_valid   = 1'b0;
    msb_first = 1'b0;
    clear     = 1'b0;
    p_ready   = 1'b1;
    exp_word  = '0;
    modelReset();
    #1;
    checkOutput("reset p_dout", {28'd0, p_dout}, 32'd0);
    checkOutput("reset p_valid", {31'd0, p_valid}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Table of single words, consumer always ready.
    for (int v = 0; v < 8; v++) begin
      sendWord(vecs[v].seq, vecs[v].msb, vecs[v].gap, 1'b1, vecs[v].expw);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // MSB-first 1,1,0,1 with gaps; msb_first toggled after the first bit.
    $display("[TB] direction latch test");
    exp_word = 4'b1101;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Back-to-back words with a stalled consumer: second word dropped.
    $display("[TB] overrun test");
    sendWord(4'b1100, 1'b0, 0, 1'b0, 4'b1100);
    sendWord(4'b0101, 1'b0, 0, 1'b0, 4'b0101);
    checkOutput("held p_dout", {28'd0, p_dout}, {28'd0, 4'b1100});
    checkOutput("overrun set", {31'd0, overrun}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("drained p_valid", {31'd0, p_valid}, 32'd0);
    checkOutput("overrun sticky", {31'd0, overrun}, 32'd1);
    checkOutput("p_dout kept", {28'd0, p_dout}, {28'd0, 4'b1100});

    // Completion on the same edge the held word is consumed.
    $display("[TB] replace-on-consume test");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    sendWord(4'b0110, 1'b0, 0, 1'b0, 4'b0110);
    exp_word = 4'b1001;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("replaced p_dout", {28'd0, p_dout}, {28'd0, 4'b1001});
    checkOutput("no overrun", {31'd0, overrun}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Abort after two bits, with a bit on the clear cycle, then a fresh word.
    $display("[TB] clear test");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    sendWord(4'b0110, 1'b0, 0, 1'b1, 4'b0110);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset with a held word and three bits of the next one.
    $display("[TB] async reset test");
    sendWord(4'b1010, 1'b0, 0, 1'b0, 4'b1010);
    exp_word = 4'b0000;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async p_valid", {31'd0, p_valid}, 32'd0);
    checkOutput("async busy", {31'd0, busy}, 32'd0);
    checkOutput("async overrun", {31'd0, overrun}, 32'd0);
    checkOutput("async p_dout", {28'd0, p_dout}, 32'd0);
    s_valid = 1'b0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    sendWord(4'b1101, 1'b1, 0, 1'b1, 4'b1011);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    checkOutput("scoreboard empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

Serial-to-parallel receiver for the stream produced by the universal shift register's serial outputs. Collects WIDTH bits qualified by a bit strobe, in LSB-first or MSB-first order, and presents each assembled word on a one-entry valid/ready output buffer. An incomplete word can be aborted, and a word lost because the output buffer is still occupied is flagged.

## Interface
- WIDTH, 4, word length in bits (≥2)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_din  in  1  serial data bit
- s_valid  in  1  s_din is a valid bit this cycle
- msb_first  in  1  0: first bit is word bit 0 (right-shift stream); 1: first bit is word bit WIDTH-1 (left-shift stream)
- clear  in  1  synchronous abort; highest priority after reset
- p_dout  out  WIDTH  assembled word, stable while p_valid
- p_valid  out  1  p_dout holds an unconsumed word
- p_ready  in  1  consumer accepts p_dout when p_valid && p_ready
- busy  out  1  partial word in progress (bit count ≠ 0)
- overrun  out  1  sticky; a completed word was dropped

## Operation
- Clock and reset: single clock `clk`; reset `rst_n` is asynchronous and active-low.
- FSM states: IDLE (count 0), SHIFT (1..WIDTH-1 bits held).
- IDLE → SHIFT on s_valid; msb_first is latched into dir on this edge.
- In SHIFT, msb_first is ignored until the word completes.
- Assembly, LSB-first: sh ← {s_din, sh[WIDTH-1:1]}.
- Assembly, MSB-first: sh ← {sh[WIDTH-2:0], s_din}.
- Bit counter: width clog2(WIDTH+1); increments per s_valid; no wrap beyond WIDTH.
- Completion: on the WIDTH-th s_valid the next-sh value is the word. State returns to IDLE and the count to 0.
- Output buffer:
  - At completion, if buffer empty or being consumed this cycle (p_valid && p_ready), p_dout ← word and p_valid ← 1.
  - Otherwise the word is dropped, overrun ← 1, and p_dout is unchanged.
  - Handshake without completion: p_valid ← 0; p_dout holds its last value.
- Back-to-back words with no idle cycle between them are supported. The first bit of the next word may arrive on the cycle after completion.
- clear:
  - Zeroes count, sh, dir, p_valid and overrun; state → IDLE. p_dout is retained.
  - A bit or handshake in the same cycle is ignored.
- s_valid low: no state change; gaps between bits are unlimited.
- busy = (state == SHIFT).

## Timing
- Reset values: p_dout=0, p_valid=0, busy=0, overrun=0; internal sh=0, count=0, dir=0.
- Latency: p_valid is high after the clock edge that samples the last bit, so it is visible in the following cycle.
- Throughput: one word per WIDTH strobes, with no dead cycle.
- p_dout/p_valid change only on a clock edge; there is no combinational path from p_ready to any output.
- overrun sets on the edge of the drop and clears only on clear or reset.
- Reset mid-word: the partial word is discarded and all outputs take their reset values immediately (asynchronous).

## Structure
- Shared package/header `shift_defs`:
  - State encoding localparams: ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - Direction constants: DIR_LSB=1'b0, DIR_MSB=1'b1.
  - Reuse this header in the shift register for select codes.
- Single module, no sub-module: shift register, counter, FSM and output buffer are each a few lines. Estimated 120-180 lines including assertions.

## Test plan
- WIDTH=4, msb_first=0, bits 1,0,1,1 on consecutive s_valid cycles, p_ready=1 → p_valid high one cycle, p_dout=4'b1101, busy low after the 4th bit.
- msb_first=1, bits 1,1,0,1 with 2-cycle gaps between bits; toggle msb_first after the first bit → p_dout=4'b1101, order unaffected by the toggle.
- Two back-to-back words 0011, 1010 (LSB-first) with p_ready=0 → first word held on p_dout=4'b1100; second dropped; overrun=1; p_dout unchanged. Then p_ready=1 → p_valid falls, overrun stays 1.
- p_valid=1 with p_ready=1 on the same edge a new word completes → new word loaded, p_valid stays 1, overrun=0.
- clear after 2 bits, then 4 fresh bits 0,1,1,0 LSB-first → p_dout=4'b0110, no residue from the aborted bits.
- Assert rst_n low mid-word (count=3) and while p_valid=1 → p_valid, busy and overrun drop asynchronously; the next full word assembles correctly.
